oam_dma: RTL
============

# oam_dma

OAM DMA controller for the NES CPU bus. A CPU write to $4014 triggers a copy of 256 bytes from CPU page $XX00, which is normally the 2 KB work RAM behind the 64 KB RAM model, to the PPU OAM data port $2004. The block sits upstream of the RAM on the CPU bus: it halts the CPU, then drives address, rw_n and cs_n in place of the CPU for 513 or 514 CPU cycles. A bus mux in the top level selects this block's outputs while `dma_active` is high.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, trigger register address.
- `OAM_DATA_ADDR`, 16'h2004, destination port address.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_ce`  in  1  one-`clk` pulse marking the last `clk` of each CPU cycle.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write in the current cycle.
- `bus_rdata`  in  8  read data returned from the bus (RAM); valid when `cpu_ce`=1.
- `bus_addr`  out  16  DMA address.
- `bus_wdata`  out  8  DMA write data.
- `bus_rw_n`  out  1  1 = read, 0 = write.
- `bus_cs_n`  out  1  active-low bus select.
- `cpu_halt`  out  1  holds the CPU (drives RDY low).
- `dma_active`  out  1  bus-ownership select for the top-level mux.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- `cycle_odd` toggles on every `cpu_ce` and resets to 0.
- Transitions are evaluated only when `cpu_ce`=1.
  - IDLE: if `cpu_we` and `cpu_addr`==`DMA_REG_ADDR`, latch `page`=`cpu_wdata`, set `idx`=0, go to HALT.
  - HALT: if the next cycle is odd (current `cycle_odd`=0), go to ALIGN; otherwise go to READ. READ always starts on an even cycle.
  - ALIGN: go to READ.
  - READ: latch `data_q`=`bus_rdata`, go to WRITE.
  - WRITE: if `idx`==255, go to IDLE. Otherwise increment `idx` and go to READ.
- `idx` is 8 bits. It never wraps inside a transfer; the check at 255 terminates it.
- Per-state outputs (registered, stable for the whole CPU cycle):
  - HALT and ALIGN: `cpu_halt`=1, `dma_active`=1, `bus_cs_n`=1, `bus_rw_n`=1.
  - READ: `bus_addr`={`page`,`idx`}, `bus_rw_n`=1, `bus_cs_n`=0.
  - WRITE: `bus_addr`=`OAM_DATA_ADDR`, `bus_wdata`=`data_q`, `bus_rw_n`=0, `bus_cs_n`=0.
  - IDLE: all outputs at their reset values.
- Writes to `DMA_REG_ADDR` outside IDLE are ignored, since the CPU is halted and the mux has it off the bus.
- Any page value is legal, including $00 and $FF. Page $20 reads PPU registers; there is no special handling.

## Timing
- Reset values: `bus_addr`=0, `bus_wdata`=0, `bus_rw_n`=1, `bus_cs_n`=1, `cpu_halt`=0, `dma_active`=0, state=IDLE, `cycle_odd`=0, `idx`=0, `page`=0, `data_q`=0.
- `rst` mid-transfer returns to IDLE on the next `clk` edge. The partial transfer is abandoned; there is no resume.
- Outputs update on the `clk` edge where `cpu_ce`=1. They are therefore valid from the first `clk` of the following CPU cycle.
- Trigger cycle T (the $4014 write) is followed by HALT at T+1.
- Total duration from the first HALT cycle to return to IDLE:
  - 513 CPU cycles when ALIGN is skipped: 1 HALT + 512 transfer cycles.
  - 514 CPU cycles when ALIGN is inserted.
- Read-to-write latency is one CPU cycle. `data_q` is captured on the READ cycle's `cpu_ce` edge, and the RAM returns data within the cycle.
- `cpu_ce` held low freezes all state and outputs.
- `cpu_ce` asserted on consecutive `clk`s is legal: each pulse is one CPU cycle.

## Structure
- Shared package `nes_pkg`:
  - state enum `dma_state_t`.
  - constants `ADDR_OAMDMA`=16'h4014 and `ADDR_OAMDATA`=16'h2004. The parameter defaults reference these.
- Single module, no sub-modules. The state register, `idx` counter, parity flop and output registers are all local.

## Test plan
- Reset then idle: 10 `cpu_ce` pulses with no writes -> `cs_n`=1, `halt`=0 throughout.
- Write $02 to $4014 on an even cycle -> HALT, no ALIGN, first READ at addr $0200. `cpu_halt` is high for exactly 513 cycles.
- Same write on an odd cycle -> ALIGN inserted, 514 cycles, and the first READ `cycle_odd`=0.
- RAM preloaded $0300–$03FF with value = low address byte XOR $A5, page $03 -> 256 writes to $2004 whose data match in order. The last READ is at $03FF.
- Reset asserted after 100 transfer cycles -> next `clk`: all outputs at reset values. A fresh $4014 write then restarts the transfer at `idx`=0.
- $4014 write issued while a transfer is active -> ignored: `page` unchanged and the total cycle count unaffected.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding
// and the CPU-bus register addresses it uses.
package nes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus driven by the OAM DMA in place of the CPU.
// master: addr/wdata/rw_n/cs_n out, rdata in. slave: mirror.
interface oam_dma_if;

  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw_n;
  logic        bus_cs_n;
  logic [7:0]  bus_rdata;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_rw_n,
    output bus_cs_n,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_rw_n,
    input  bus_cs_n,
    output bus_rdata
  );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: a $4014 write copies page $XX00-$XXFF to $2004.
// Ports: clk, rst, cpu_ce/addr/wdata/we in; bus (master) out;
// cpu_halt, dma_active out.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  oam_dma_if.master   bus,
  output logic        cpu_halt,
  output logic        dma_active
);

  dma_state_t  r_state, w_state;
  logic        r_odd;
  logic [7:0]  r_idx, w_idx;
  logic [7:0]  r_page, w_page;
  logic [7:0]  r_dq, w_dq;

  logic [15:0] r_addr, w_addr;
  logic [7:0]  r_wdata, w_wdata;
  logic        r_rw_n, w_rw_n;
  logic        r_cs_n, w_cs_n;
  logic        r_halt, w_halt;
  logic        r_act, w_act;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_page  = r_page;
    w_dq    = r_dq;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
          w_page  = cpu_wdata;
          w_idx   = 8'h00;
          w_state = S_HALT;
        end
      end
      // r_odd=0 here means the next cycle is odd:
      // burn one so READ lands on an even cycle
      S_HALT:  w_state = r_odd ? S_READ : S_ALIGN;
      S_ALIGN: w_state = S_READ;
      S_READ: begin
        w_dq    = bus.bus_rdata;
        w_state = S_WRITE;
      end
      S_WRITE: begin
        if (r_idx == 8'hFF) begin
          w_state = S_IDLE;
        end else begin
          w_idx   = r_idx + 8'h01;
          w_state = S_READ;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are
  // registered together with it.
  always_comb begin
    w_addr  = 16'h0000;
    w_wdata = 8'h00;
    w_rw_n  = 1'b1;
    w_cs_n  = 1'b1;
    w_halt  = 1'b0;
    w_act   = 1'b0;
    unique case (1'b1)
      (w_state == S_HALT),
      (w_state == S_ALIGN): begin
        w_halt = 1'b1;
        w_act  = 1'b1;
      end
      (w_state == S_READ): begin
        w_halt = 1'b1;
        w_act  = 1'b1;
        w_addr = {w_page, w_idx};
        w_cs_n = 1'b0;
      end
      (w_state == S_WRITE): begin
        w_halt  = 1'b1;
        w_act   = 1'b1;
        w_addr  = OAM_DATA_ADDR;
        w_wdata = w_dq;
        w_rw_n  = 1'b0;
        w_cs_n  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_odd   <= 1'b0;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_dq    <= 8'h00;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_rw_n  <= 1'b1;
      r_cs_n  <= 1'b1;
      r_halt  <= 1'b0;
      r_act   <= 1'b0;
    end else if (cpu_ce) begin
      r_state <= w_state;
      r_odd   <= ~r_odd;
      r_idx   <= w_idx;
      r_page  <= w_page;
      r_dq    <= w_dq;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rw_n  <= w_rw_n;
      r_cs_n  <= w_cs_n;
      r_halt  <= w_halt;
      r_act   <= w_act;
    end
  end

  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_rw_n  = r_rw_n;
  assign bus.bus_cs_n  = r_cs_n;
  assign cpu_halt      = r_halt;
  assign dma_active    = r_act;

endmodule
